pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline register bank: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-stage load enables and bubble (flush) strobes for those registers.
- Handles four conditions: cache stalls, the multicycle multiply/divide unit (MDU) in EX, taken-branch squash and load-use interlock.
- Sits beside the datapath; its outputs drive the load/flush inputs of every pipeline register.

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the 5-stage pipeline register bank.
// The master side belongs to the sequencer; the slave side belongs to the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             icache_stall;
  logic             dcache_stall;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mdu_op;
  logic             ex_br_taken;

  logic             ld_pc;
  logic             ld_ifid;
  logic             ld_idex;
  logic             ld_exmem;
  logic             ld_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  icache_stall, dcache_stall, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_memread, ex_rd, ex_mdu_op, ex_br_taken,
    output ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb,
           flush_ifid, flush_idex, flush_exmem, mdu_done, stall_cnt, flush_cnt
  );

  modport slave (
    output icache_stall, dcache_stall, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_memread, ex_rd, ex_mdu_op, ex_br_taken,
    input  ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb,
           flush_ifid, flush_idex, flush_exmem, mdu_done, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load enables and bubble strobes for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input logic                clk,
  input logic                rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam int unsigned MduCntW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMduBusy = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e               state_q, state_d;
  state_e               saved_q, saved_d;
  state_e               eff_state;
  logic [MduCntW-1:0]   mdu_cnt_q, mdu_cnt_d;

  logic [REG_W-1:0]     ex_rd;
  logic                 cache_stall;
  logic                 load_use;
  logic                 br_squash;

  logic ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb;
  logic flush_ifid, flush_idex, flush_exmem, mdu_done;

  assign ex_rd       = bus.ex_rd;
  assign cache_stall = bus.icache_stall | bus.dcache_stall;
  assign load_use    = bus.ex_memread && (ex_rd != '0) &&
                       ((bus.id_use_rs && (bus.id_rs == ex_rd)) ||
                        (bus.id_use_rt && (bus.id_rt == ex_rd)));

  // Leaving MEM_WAIT behaves as the saved state in the same cycle, so decode on the effective state.
  assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    mdu_cnt_d   = mdu_cnt_q;
    ld_pc       = 1'b1;
    ld_ifid     = 1'b1;
    ld_idex     = 1'b1;
    ld_exmem    = 1'b1;
    ld_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    mdu_done    = 1'b0;
    br_squash   = 1'b0;

    if (cache_stall) begin
      ld_pc    = 1'b0;
      ld_ifid  = 1'b0;
      ld_idex  = 1'b0;
      ld_exmem = 1'b0;
      ld_memwb = 1'b0;
      state_d  = StMemWait;
      if (state_q != StMemWait) saved_d = state_q;
    end else begin
      state_d = eff_state;
      case (eff_state)
        StMduBusy: begin
          if (mdu_cnt_q != '0) begin
            ld_pc       = 1'b0;
            ld_ifid     = 1'b0;
            ld_idex     = 1'b0;
            flush_exmem = 1'b1;
            mdu_cnt_d   = mdu_cnt_q - MduCntW'(1);
          end else begin
            mdu_done = 1'b1;
            state_d  = StRun;
          end
        end
        default: begin
          if (bus.ex_mdu_op) begin
            // First EX cycle of the op; the remaining MDU_LAT-1 cycles run in MDU_BUSY.
            ld_pc       = 1'b0;
            ld_ifid     = 1'b0;
            ld_idex     = 1'b0;
            flush_exmem = 1'b1;
            mdu_cnt_d   = MduCntW'(MDU_LAT - 2);
            state_d     = StMduBusy;
          end else if (bus.ex_br_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            br_squash  = 1'b1;
          end else if (load_use) begin
            ld_pc      = 1'b0;
            ld_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
      endcase
    end

    if (rst) begin
      ld_pc       = 1'b0;
      ld_ifid     = 1'b0;
      ld_idex     = 1'b0;
      ld_exmem    = 1'b0;
      ld_memwb    = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      mdu_done    = 1'b0;
      br_squash   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      saved_q   <= StRun;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign bus.ld_pc       = ld_pc;
  assign bus.ld_ifid     = ld_ifid;
  assign bus.ld_idex     = ld_idex;
  assign bus.ld_exmem    = ld_exmem;
  assign bus.ld_memwb    = ld_memwb;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.flush_exmem = flush_exmem;
  assign bus.mdu_done    = mdu_done;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ld_pc)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_squash) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_br_squash;
  assign unused_br_squash = br_squash;
  assign bus.stall_cnt    = {CNT_W{1'b0}};
  assign bus.flush_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MDU_LAT=4); counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  // {ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb, flush_ifid, flush_idex, flush_exmem, mdu_done}
  localparam logic [8:0] CtlOff  = 9'b00000_000_0;
  localparam logic [8:0] CtlRun  = 9'b11111_000_0;
  localparam logic [8:0] CtlMdu  = 9'b00011_001_0;
  localparam logic [8:0] CtlDone = 9'b11111_000_1;
  localparam logic [8:0] CtlBr   = 9'b11111_110_0;
  localparam logic [8:0] CtlLu   = 9'b00111_010_0;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [8:0]  ctl;
  logic [31:0] exp_cnt;

  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.REG_W(5), .MDU_LAT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign ctl = {bus.ld_pc, bus.ld_ifid, bus.ld_idex, bus.ld_exmem, bus.ld_memwb,
                bus.flush_ifid, bus.flush_idex, bus.flush_exmem, bus.mdu_done};

  task automatic clear_inputs();
    bus.icache_stall = 1'b0;
    bus.dcache_stall = 1'b0;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_use_rs    = 1'b0;
    bus.id_use_rt    = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.ex_rd        = '0;
    bus.ex_mdu_op    = 1'b0;
    bus.ex_br_taken  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (ctl !== CtlOff) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want %b", ctl, CtlOff);
    end
    vectors++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlRun) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", ctl, CtlRun);
    end
    tick();
  endtask

  task automatic test_mdu();
    reset_dut();
    bus.ex_mdu_op = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== CtlMdu) begin
        miscompares++;
        $display("FAIL mdu_busy_c%0d: got %b want %b", c, ctl, CtlMdu);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (ctl !== CtlDone) begin
      miscompares++;
      $display("FAIL mdu_done_c4: got %b want %b", ctl, CtlDone);
    end
    tick();
    bus.ex_mdu_op = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlRun) begin
      miscompares++;
      $display("FAIL mdu_after: got %b want %b", ctl, CtlRun);
    end
    exp_cnt = Perf ? 32'd3 : 32'd0;
    vectors++;
    if (bus.stall_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL mdu_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_mdu_dstall();
    logic [8:0] want [1:6];
    want[1] = CtlMdu;
    want[2] = CtlMdu;
    want[3] = CtlOff;
    want[4] = CtlOff;
    want[5] = CtlMdu;
    want[6] = CtlDone;
    reset_dut();
    bus.ex_mdu_op = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      bus.dcache_stall = (c == 3 || c == 4);
      @(negedge clk);
      vectors++;
      if (ctl !== want[c]) begin
        miscompares++;
        $display("FAIL mdu_dstall_c%0d: got %b want %b", c, ctl, want[c]);
      end
      tick();
    end
    bus.ex_mdu_op    = 1'b0;
    bus.dcache_stall = 1'b0;
    @(negedge clk);
    exp_cnt = Perf ? 32'd5 : 32'd0;
    vectors++;
    if (ctl !== CtlRun || bus.stall_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL mdu_dstall_after: got %b/%0d want %b/%0d", ctl, bus.stall_cnt, CtlRun, exp_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    reset_dut();
    bus.ex_memread = 1'b1;
    bus.ex_rd      = 5'd8;
    bus.id_rs      = 5'd8;
    bus.id_use_rs  = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlLu) begin
      miscompares++;
      $display("FAIL lu_rs: got %b want %b", ctl, CtlLu);
    end
    tick();
    // Load moved to MEM; a bubble now sits in EX.
    bus.ex_memread = 1'b0;
    bus.ex_rd      = 5'd0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlRun) begin
      miscompares++;
      $display("FAIL lu_clear: got %b want %b", ctl, CtlRun);
    end
    tick();
    bus.ex_memread = 1'b1;
    bus.ex_rd      = 5'd0;
    bus.id_rs      = 5'd0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlRun) begin
      miscompares++;
      $display("FAIL lu_rd0: got %b want %b", ctl, CtlRun);
    end
    tick();
    bus.ex_rd     = 5'd17;
    bus.id_rs     = 5'd3;
    bus.id_rt     = 5'd17;
    bus.id_use_rt = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlLu) begin
      miscompares++;
      $display("FAIL lu_rt: got %b want %b", ctl, CtlLu);
    end
    tick();
    bus.id_use_rt = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlRun) begin
      miscompares++;
      $display("FAIL lu_rt_unused: got %b want %b", ctl, CtlRun);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    reset_dut();
    bus.ex_memread  = 1'b1;
    bus.ex_rd       = 5'd8;
    bus.id_rs       = 5'd8;
    bus.id_use_rs   = 1'b1;
    bus.ex_br_taken = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlBr) begin
      miscompares++;
      $display("FAIL br_over_lu: got %b want %b", ctl, CtlBr);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    exp_cnt = Perf ? 32'd1 : 32'd0;
    vectors++;
    if (bus.flush_cnt !== exp_cnt || bus.stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL br_cnt: got flush %0d stall %0d want flush %0d stall 0",
               bus.flush_cnt, bus.stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_icache();
    reset_dut();
    bus.icache_stall = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      bus.ex_br_taken = (c == 2);
      @(negedge clk);
      vectors++;
      if (ctl !== CtlOff) begin
        miscompares++;
        $display("FAIL icache_c%0d: got %b want %b", c, ctl, CtlOff);
      end
      tick();
    end
    bus.icache_stall = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlRun) begin
      miscompares++;
      $display("FAIL icache_release: got %b want %b", ctl, CtlRun);
    end
    exp_cnt = Perf ? 32'd5 : 32'd0;
    vectors++;
    if (bus.stall_cnt !== exp_cnt || bus.flush_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL icache_cnt: got stall %0d flush %0d want stall %0d flush 0",
               bus.stall_cnt, bus.flush_cnt, exp_cnt);
    end
    tick();
    // Stall over a pending load-use; the hazard must act in the release cycle.
    bus.icache_stall = 1'b1;
    bus.ex_memread   = 1'b1;
    bus.ex_rd        = 5'd4;
    bus.id_rt        = 5'd4;
    bus.id_use_rt    = 1'b1;
    tick();
    bus.icache_stall = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlLu) begin
      miscompares++;
      $display("FAIL memwait_to_lu: got %b want %b", ctl, CtlLu);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    reset_dut();
    bus.ex_mdu_op = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CtlOff) begin
      miscompares++;
      $display("FAIL midrst_ctl: got %b want %b", ctl, CtlOff);
    end
    tick();
    bus.ex_mdu_op = 1'b0;
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== CtlRun) begin
        miscompares++;
        $display("FAIL midrst_after_c%0d: got %b want %b", c, ctl, CtlRun);
      end
      tick();
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    vectors     = 0;
    miscompares = 0;
    clear_inputs();
    test_reset();
    test_mdu();
    test_mdu_dstall();
    test_load_use();
    test_branch();
    test_icache();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
